// File: rtl/camera_ctrl_pkg.sv
// Shared types and constants for the camera operation sequencer.
// Contents: sequencer state type, operation channel indices, arbitration
// mode selectors, and an index-width helper.
package camera_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_INIT  = 2'd1,
      ST_IDLE  = 2'd2,
      ST_RUN   = 2'd3
   } state_t;

   // Operation channel indices
   localparam int unsigned OP_PHOTO = 0;
   localparam int unsigned OP_SEND  = 1;

   // Arbitration modes
   localparam int unsigned MODE_FIXED = 0;
   localparam int unsigned MODE_RR    = 1;

   // Bits needed to hold an index in 0..n-1. Always at least 1.
   function automatic int unsigned bits_for(int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/camera_op_sequencer_if.sv
// Bundle of request/response signals between the user/datapath side
// (master) and the operation sequencer (slave).
//   done_init : device init complete
//   req       : level request per op channel
//   done      : op complete per channel
//   init      : init start pulse
//   start     : one-hot op start pulse
//   busy      : op in flight
//   active_op : granted op index
//   ready     : sequencer idle
//   err       : final-timeout pulse
//   err_op    : index of the last failed op
interface camera_op_sequencer_if
   import camera_ctrl_pkg::*;
#(
   parameter int unsigned NUM_OPS = 2
);
   localparam int unsigned IDX_W = bits_for(NUM_OPS);

   logic               done_init;
   logic [NUM_OPS-1:0] req;
   logic [NUM_OPS-1:0] done;
   logic               init;
   logic [NUM_OPS-1:0] start;
   logic               busy;
   logic [IDX_W-1:0]   active_op;
   logic               ready;
   logic               err;
   logic [IDX_W-1:0]   err_op;

   modport master (
      output done_init, req, done,
      input  init, start, busy, active_op, ready, err, err_op
   );

   modport slave (
      input  done_init, req, done,
      output init, start, busy, active_op, ready, err, err_op
   );

endinterface

// File: rtl/op_arbiter.sv
// Request arbiter for the operation sequencer.
// Fixed mode: lowest requesting index wins. Round-robin mode: search starts
// at the pointer and wraps; the pointer moves past the winner on advance.
//   clock, reset : clock and synchronous active-high reset
//   req          : level requests
//   advance      : the current grant has been taken
//   grant        : winning index (valid with grant_valid)
//   grant_valid  : at least one request is pending
module op_arbiter
   import camera_ctrl_pkg::*;
#(
   parameter int unsigned NUM_OPS = 2,
   parameter int unsigned RR_MODE = MODE_FIXED,
   localparam int unsigned IDX_W  = bits_for(NUM_OPS)
)(
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_OPS-1:0] req,
   input  logic               advance,
   output logic [IDX_W-1:0]   grant,
   output logic               grant_valid
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);

   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] cand;

   // Walk every channel once, starting at the pointer (or 0 in fixed mode),
   // and keep the first requester found.
   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      cand        = (RR_MODE == MODE_RR) ? ptr : '0;
      for (int unsigned i = 0; i < NUM_OPS; i++) begin
         if (!grant_valid && req[cand]) begin
            grant       = cand;
            grant_valid = 1'b1;
         end
         cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ptr <= '0;
      end else if (RR_MODE == MODE_RR && advance && grant_valid) begin
         ptr <= (grant == LAST_IDX) ? '0 : grant + 1'b1;
      end
   end

endmodule

// File: rtl/camera_op_sequencer.sv
// Camera operation sequencer: initialises the device, then runs one
// operation at a time, chosen from level requests. Each start and init
// pulse is followed by a timeout window; op timeouts are retried a bounded
// number of times before an error pulse and a full device re-init.
// All outputs are registered.
//   clock, reset : clock and synchronous active-high reset
//   bus          : sequencer side of camera_op_sequencer_if
module camera_op_sequencer
   import camera_ctrl_pkg::*;
#(
   parameter int unsigned NUM_OPS   = 2,
   parameter int unsigned TIMEOUT_W = 16,
   parameter int unsigned TIMEOUT   = 50000,
   parameter int unsigned MAX_RETRY = 2,
   parameter int unsigned RR_MODE   = MODE_FIXED
)(
   input  logic                 clock,
   input  logic                 reset,
   camera_op_sequencer_if.slave bus
);

   localparam int unsigned IDX_W   = bits_for(NUM_OPS);
   localparam int unsigned RETRY_W = bits_for(MAX_RETRY + 1);
   localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT - 1);

   state_t               state, state_n;
   logic [TIMEOUT_W-1:0] timer, timer_n;
   logic [RETRY_W-1:0]   retries, retries_n;
   logic [IDX_W-1:0]     op_q, op_n;
   logic [IDX_W-1:0]     err_op_q, err_op_n;
   logic                 init_q, init_n;
   logic [NUM_OPS-1:0]   start_q, start_n;
   logic                 busy_q, busy_n;
   logic                 ready_q, ready_n;
   logic                 err_q, err_n;

   logic [IDX_W-1:0]     gnt;
   logic                 gnt_valid;
   logic                 advance;

   op_arbiter #(
      .NUM_OPS (NUM_OPS),
      .RR_MODE (RR_MODE)
   ) u_arb (
      .clock       (clock),
      .reset       (reset),
      .req         (bus.req),
      .advance     (advance),
      .grant       (gnt),
      .grant_valid (gnt_valid)
   );

   // The timer is held at 0 during the cycle a pulse is on the outputs, so
   // counting begins the cycle after the pulse and a timeout fires
   // TIMEOUT cycles after it.
   always_comb begin
      state_n   = state;
      timer_n   = timer;
      retries_n = retries;
      op_n      = op_q;
      err_op_n  = err_op_q;
      init_n    = 1'b0;
      start_n   = '0;
      busy_n    = 1'b0;
      ready_n   = 1'b0;
      err_n     = 1'b0;
      advance   = 1'b0;

      case (state)
         ST_START: begin
            state_n = ST_INIT;
            init_n  = 1'b1;
            timer_n = '0;
         end

         ST_INIT: begin
            if (bus.done_init) begin
               state_n = ST_IDLE;
               ready_n = 1'b1;
            end else if (!init_q) begin
               if (timer == TMO_LAST) state_n = ST_START;
               else                   timer_n = timer + 1'b1;
            end
         end

         ST_IDLE: begin
            if (gnt_valid) begin
               state_n      = ST_RUN;
               busy_n       = 1'b1;
               start_n[gnt] = 1'b1;
               op_n         = gnt;
               timer_n      = '0;
               retries_n    = '0;
               advance      = 1'b1;
            end else begin
               ready_n = 1'b1;
            end
         end

         ST_RUN: begin
            busy_n = 1'b1;
            // Completion takes precedence over a coincident timeout.
            if (bus.done[op_q]) begin
               state_n   = ST_IDLE;
               busy_n    = 1'b0;
               ready_n   = 1'b1;
               retries_n = '0;
            end else if (start_q == '0) begin
               if (timer != TMO_LAST) begin
                  timer_n = timer + 1'b1;
               end else if (32'(retries) < MAX_RETRY) begin
                  retries_n     = retries + 1'b1;
                  timer_n       = '0;
                  start_n[op_q] = 1'b1;
               end else begin
                  state_n   = ST_START;
                  busy_n    = 1'b0;
                  err_n     = 1'b1;
                  err_op_n  = op_q;
                  retries_n = '0;
               end
            end
         end

         default: state_n = ST_START;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= ST_START;
         timer    <= '0;
         retries  <= '0;
         op_q     <= '0;
         err_op_q <= '0;
         init_q   <= 1'b0;
         start_q  <= '0;
         busy_q   <= 1'b0;
         ready_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_n;
         timer    <= timer_n;
         retries  <= retries_n;
         op_q     <= op_n;
         err_op_q <= err_op_n;
         init_q   <= init_n;
         start_q  <= start_n;
         busy_q   <= busy_n;
         ready_q  <= ready_n;
         err_q    <= err_n;
      end
   end

   assign bus.init      = init_q;
   assign bus.start     = start_q;
   assign bus.busy      = busy_q;
   assign bus.active_op = op_q;
   assign bus.ready     = ready_q;
   assign bus.err       = err_q;
   assign bus.err_op    = err_op_q;

endmodule

// File: tb/tb_camera_op_sequencer.sv
// Bench for camera_op_sequencer: a round-robin and a fixed-priority
// instance (3 ops, TIMEOUT=8, MAX_RETRY=2) driven side by side, compared
// every cycle against a transaction-level model, plus literal checks of
// pulse spacing, grant order, retry/error timing and reset behaviour.
module tb_camera_op_sequencer;
   import camera_ctrl_pkg::*;

   localparam int N    = 3;
   localparam int TMO  = 8;
   localparam int MAXR = 2;

   // Model phases
   localparam int P_WAKE = 0;
   localparam int P_INIT = 1;
   localparam int P_IDLE = 2;
   localparam int P_RUN  = 3;

   // age = cycles since the most recent init/start pulse (pulse cycle = 0)
   typedef struct packed {
      int phase;
      int age;
      int tries;
      int g;
      int ptr;
      int err_op;
      int start_idx;
      bit init;
      bit ready;
      bit busy;
      bit err;
   } model_t;

   logic   clock = 1'b0;
   logic   reset;
   int     vectors = 0;
   int     miscompares = 0;
   model_t m_rr, m_fx;
   bit     armed = 1'b0;

   camera_op_sequencer_if #(.NUM_OPS(N)) bus_rr ();
   camera_op_sequencer_if #(.NUM_OPS(N)) bus_fx ();

   camera_op_sequencer #(
      .NUM_OPS(N), .TIMEOUT_W(4), .TIMEOUT(TMO), .MAX_RETRY(MAXR), .RR_MODE(MODE_RR)
   ) dut_rr (
      .clock(clock), .reset(reset), .bus(bus_rr)
   );

   camera_op_sequencer #(
      .NUM_OPS(N), .TIMEOUT_W(4), .TIMEOUT(TMO), .MAX_RETRY(MAXR), .RR_MODE(MODE_FIXED)
   ) dut_fx (
      .clock(clock), .reset(reset), .bus(bus_fx)
   );

   always #5 clock = ~clock;

   task automatic chk(string name, int act, int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic lit2(string name, int a_rr, int a_fx, int exp);
      chk({name, ".rr"}, a_rr, exp);
      chk({name, ".fx"}, a_fx, exp);
   endtask

   function automatic model_t model_reset();
      model_t r;
      r = '0;
      r.phase = P_WAKE;
      r.start_idx = -1;
      return r;
   endfunction

   // Winner: first requester at or above ptr, else first requester overall.
   function automatic int pick(logic [N-1:0] r, int ptr);
      for (int i = ptr; i < N; i++) if (r[i]) return i;
      for (int i = 0; i < N; i++) if (r[i]) return i;
      return -1;
   endfunction

   function automatic int onehot_idx(logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   // Outputs visible in the next cycle, given this cycle's view and inputs.
   function automatic model_t step(model_t m, logic rst, logic di,
                                   logic [N-1:0] rq, logic [N-1:0] dn, bit rr);
      model_t n;
      int p;
      if (rst) return model_reset();
      n = m;
      n.init = 1'b0; n.ready = 1'b0; n.busy = 1'b0; n.err = 1'b0;
      n.start_idx = -1;
      case (m.phase)
         P_WAKE: begin n.phase = P_INIT; n.init = 1'b1; n.age = 0; end
         P_INIT: begin
            if (di) begin n.phase = P_IDLE; n.ready = 1'b1; end
            else if (m.age == TMO) n.phase = P_WAKE;
            else n.age = m.age + 1;
         end
         P_IDLE: begin
            p = pick(rq, rr ? m.ptr : 0);
            if (p < 0) n.ready = 1'b1;
            else begin
               n.phase = P_RUN; n.busy = 1'b1; n.start_idx = p; n.g = p;
               n.age = 0; n.tries = 0;
               if (rr) n.ptr = (p + 1) % N;
            end
         end
         P_RUN: begin
            if (dn[m.g]) begin n.phase = P_IDLE; n.ready = 1'b1; end
            else if (m.age == TMO) begin
               if (m.tries < MAXR) begin
                  n.busy = 1'b1; n.tries = m.tries + 1; n.age = 0; n.start_idx = m.g;
               end else begin
                  n.phase = P_WAKE; n.err = 1'b1; n.err_op = m.g;
               end
            end else begin
               n.busy = 1'b1; n.age = m.age + 1;
            end
         end
         default: n = model_reset();
      endcase
      return n;
   endfunction

   always @(posedge clock) begin
      m_rr  <= step(m_rr, reset, bus_rr.done_init, bus_rr.req, bus_rr.done, 1'b1);
      m_fx  <= step(m_fx, reset, bus_fx.done_init, bus_fx.req, bus_fx.done, 1'b0);
      armed <= 1'b1;
   end

   task automatic cmp(string t, model_t m, logic init, logic [N-1:0] st, logic busy,
                      logic ready, logic err, logic [1:0] aop, logic [1:0] eop);
      chk({t, ".init"},   int'(init),  int'(m.init));
      chk({t, ".start"},  int'(st),    (m.start_idx < 0) ? 0 : (1 << m.start_idx));
      chk({t, ".busy"},   int'(busy),  int'(m.busy));
      chk({t, ".ready"},  int'(ready), int'(m.ready));
      chk({t, ".err"},    int'(err),   int'(m.err));
      chk({t, ".err_op"}, int'(eop),   m.err_op);
      if (m.busy) chk({t, ".active_op"}, int'(aop), m.g);
   endtask

   always @(negedge clock) begin
      if (armed) begin
         cmp("rr", m_rr, bus_rr.init, bus_rr.start, bus_rr.busy, bus_rr.ready,
             bus_rr.err, bus_rr.active_op, bus_rr.err_op);
         cmp("fx", m_fx, bus_fx.init, bus_fx.start, bus_fx.busy, bus_fx.ready,
             bus_fx.err, bus_fx.active_op, bus_fx.err_op);
      end
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic set_all(logic di, logic [N-1:0] rq, logic [N-1:0] dn);
      bus_rr.done_init = di; bus_rr.req = rq; bus_rr.done = dn;
      bus_fx.done_init = di; bus_fx.req = rq; bus_fx.done = dn;
   endtask

   initial begin
      int pulses[$];
      int exp_b[3] = '{1, 11, 21};
      int ord_rr[$], ord_fx[$];
      int exp_rr[4] = '{0, 1, 2, 0};
      int starts[$];
      int exp_d[3] = '{0, 9, 18};
      int due_rr, due_fx, g_rr, g_fx, t_err, t_init, eop;

      // Reset release; done_init in cycle 3
      reset = 1'b1;
      set_all(1'b0, '0, '0);
      tick(); tick(); tick();
      reset = 1'b0;                         // cycle 0 (START)
      tick();                               // cycle 1
      lit2("A.init_c1", int'(bus_rr.init), int'(bus_fx.init), 1);
      lit2("A.ready_c1", int'(bus_rr.ready), int'(bus_fx.ready), 0);
      tick(); tick();                       // cycle 3
      set_all(1'b1, '0, '0);
      tick();                               // cycle 4
      set_all(1'b0, '0, '0);
      lit2("A.ready_c4", int'(bus_rr.ready), int'(bus_fx.ready), 1);
      lit2("A.busy_c4", int'(bus_rr.busy), int'(bus_fx.busy), 0);

      // Init timeout: pulse every TIMEOUT+2 cycles, then done_init
      reset = 1'b1;
      tick();
      reset = 1'b0;                         // cycle 0
      for (int c = 1; c <= 22; c++) begin
         tick();
         if (bus_rr.init) pulses.push_back(c);
         if (c == 22) set_all(1'b1, '0, '0);
      end
      tick();
      set_all(1'b0, '0, '0);
      chk("B.pulse_count", pulses.size(), 3);
      for (int i = 0; i < 3; i++)
         chk("B.pulse_cycle", (i < pulses.size()) ? pulses[i] : -1, exp_b[i]);
      lit2("B.ready", int'(bus_rr.ready), int'(bus_fx.ready), 1);

      // Grant order with all requests held, done two cycles after each start
      due_rr = -1; due_fx = -1; g_rr = 0; g_fx = 0;
      set_all(1'b0, 3'b111, '0);
      for (int k = 0; k < 24; k++) begin
         tick();
         bus_rr.done = '0;
         bus_fx.done = '0;
         if (k == due_rr) bus_rr.done = 3'b001 << g_rr;
         if (k == due_fx) bus_fx.done = 3'b001 << g_fx;
         if (bus_rr.start != '0) begin
            g_rr = onehot_idx(bus_rr.start); ord_rr.push_back(g_rr); due_rr = k + 2;
         end
         if (bus_fx.start != '0) begin
            g_fx = onehot_idx(bus_fx.start); ord_fx.push_back(g_fx); due_fx = k + 2;
         end
         if (ord_rr.size() >= 4) bus_rr.req = '0;
         if (ord_fx.size() >= 4) bus_fx.req = '0;
      end
      lit2("C.grant_count", ord_rr.size(), ord_fx.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk("C.rr_order", (i < ord_rr.size()) ? ord_rr[i] : -1, exp_rr[i]);
         chk("C.fx_order", (i < ord_fx.size()) ? ord_fx[i] : -1, OP_PHOTO);
      end

      // Op 1 never completes: retries, then error and re-init
      t_err = -1; t_init = -1; eop = -1;
      set_all(1'b0, 3'b010, '0);
      for (int k = 0; k < 32; k++) begin
         tick();
         if (bus_rr.start[OP_SEND]) begin
            starts.push_back(k);
            set_all(1'b0, '0, '0);
         end
         if (bus_rr.err && t_err < 0) begin t_err = k; eop = int'(bus_rr.err_op); end
         if (bus_rr.init && t_init < 0) t_init = k;
      end
      chk("D.start_count", starts.size(), 3);
      for (int i = 0; i < 3; i++)
         chk("D.start_offset", (i < starts.size()) ? starts[i] - starts[0] : -1, exp_d[i]);
      chk("D.err_offset", (starts.size() > 0) ? t_err - starts[0] : -1, 27);
      chk("D.init_offset", (starts.size() > 0) ? t_init - starts[0] : -1, 28);
      chk("D.err_op", eop, OP_SEND);
      set_all(1'b1, '0, '0);
      tick();
      set_all(1'b0, '0, '0);
      lit2("D.ready", int'(bus_rr.ready), int'(bus_fx.ready), 1);
      lit2("D.err_op_held", int'(bus_rr.err_op), int'(bus_fx.err_op), OP_SEND);

      // done[1] coincides with the first timeout
      set_all(1'b0, 3'b010, '0);
      tick();                               // start cycle s
      lit2("E.start", int'(bus_rr.start), int'(bus_fx.start), 2);
      set_all(1'b0, '0, '0);
      for (int i = 0; i < 8; i++) tick();   // s+8
      set_all(1'b0, '0, 3'b010);
      tick();                               // s+9
      set_all(1'b0, '0, '0);
      lit2("E.no_retry", int'(bus_rr.start), int'(bus_fx.start), 0);
      lit2("E.no_err", int'(bus_rr.err), int'(bus_fx.err), 0);
      lit2("E.ready", int'(bus_rr.ready), int'(bus_fx.ready), 1);

      // Reset while running, timer at 4
      set_all(1'b0, 3'b001, '0);
      tick();                               // start cycle s
      lit2("F.start", int'(bus_rr.start), int'(bus_fx.start), 1);
      set_all(1'b0, '0, '0);
      for (int i = 0; i < 5; i++) tick();   // s+5
      reset = 1'b1;
      tick();                               // s+6
      reset = 1'b0;
      lit2("F.busy", int'(bus_rr.busy), int'(bus_fx.busy), 0);
      lit2("F.start0", int'(bus_rr.start), int'(bus_fx.start), 0);
      lit2("F.err", int'(bus_rr.err), int'(bus_fx.err), 0);
      lit2("F.err_op", int'(bus_rr.err_op), int'(bus_fx.err_op), 0);
      tick();                               // s+7: START processed
      lit2("F.init", int'(bus_rr.init), int'(bus_fx.init), 1);
      set_all(1'b1, '0, '0);
      tick();
      set_all(1'b0, '0, '0);
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
